sltu: RTL and testbench

SLTU -- requirements
Module: sltu

---
 rtl/sltu_pkg.sv | 8 +
 rtl/sltu_adder_n.sv | 28 ++
 rtl/sltu.sv | 56 +++++
 tb/tb_sltu.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sltu_pkg.sv
// Shared constants for the unsigned set-less-than comparator.
// Imported by sltu (top) and adder_n (carry-chain sub-module).
package sltu_pkg;

    localparam int unsigned SLTU_DEFAULT_N = 32;
    localparam int unsigned SLTU_MAX_N     = 64;

endpackage : sltu_pkg

// File: rtl/sltu_adder_n.sv
// Parameterized N-bit ripple-carry adder built from per-bit full-adder logic.
// Used by sltu to form a + ~b + 1; only the carry-out matters there.
module adder_n
    import sltu_pkg::*;
#(
    parameter int unsigned N = SLTU_DEFAULT_N
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        logic p;
        assign p            = x[i] ^ y[i];
        assign sum[i]       = p ^ carry[i];
        assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & p);
    end

    assign cout = carry[N];

endmodule : adder_n

// File: rtl/sltu.sv
// Unsigned a < b comparator via the carry-out of a + ~b + 1, plus equality flag.
// Macro SLTU_REG_OUT_EN: when defined lt_q is a flop of lt, otherwise lt_q = lt.
module sltu
    import sltu_pkg::*;
#(
    parameter int unsigned N = SLTU_DEFAULT_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt,
    output logic         eq,
    output logic         lt_q,
    input  logic         clk,
    input  logic         rst_n
);

    logic [N-1:0] diff_unused;
    logic         no_borrow;

    // A carry out of a + ~b + 1 means no borrow, i.e. a >= b unsigned.
    adder_n #(
        .N (N)
    ) u_sub (
        .x    (a),
        .y    (~b),
        .cin  (1'b1),
        .sum  (diff_unused),
        .cout (no_borrow)
    );

    assign lt = ~no_borrow;
    assign eq = ~|(a ^ b);

`ifdef SLTU_REG_OUT_EN
    logic lt_out_d;
    logic lt_out_q;

    assign lt_out_d = lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_out_q <= 1'b0;
        end else begin
            lt_out_q <= lt_out_d;
        end
    end

    assign lt_q = lt_out_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign lt_q           = lt;
`endif

endmodule : sltu

// File: tb/tb_sltu.sv
// Directed bench for sltu: N=32 main instance plus N=2 and N=1 instances.
module tb_sltu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a32, b32;
    logic        lt32, eq32, ltq32;
    logic [1:0]  a2, b2;
    logic        lt2, eq2, ltq2;
    logic        a1, b1;
    logic        lt1, eq1, ltq1;

    int checks = 0;
    int errors = 0;

    sltu #(.N(32)) dut32 (
        .a(a32), .b(b32), .lt(lt32), .eq(eq32), .lt_q(ltq32), .clk(clk), .rst_n(rst_n)
    );
    sltu #(.N(2)) dut2 (
        .a(a2), .b(b2), .lt(lt2), .eq(eq2), .lt_q(ltq2), .clk(clk), .rst_n(rst_n)
    );
    sltu #(.N(1)) dut1 (
        .a(a1), .b(b1), .lt(lt1), .eq(eq1), .lt_q(ltq1), .clk(clk), .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        a32 = '0; b32 = '0; a2 = '0; b2 = '0; a1 = 1'b0; b1 = 1'b0;
        #1;
        check("reset_eq_zero_operands", eq32, 1'b1);
        check("reset_lt_zero_operands", lt32, 1'b0);
`ifdef SLTU_REG_OUT_EN
        check("reset_ltq", ltq32, 1'b0);
`endif
        // reset must not touch the combinational flags
        a32 = 32'd1; b32 = 32'd2;
        #1;
        check("reset_lt_comb", lt32, 1'b1);
        a32 = '0; b32 = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef SLTU_REG_OUT_EN
        // registered path: value appears only after the edge
        a32 = 32'd1; b32 = 32'd2;
        #1;
        check("reg_ltq_before_edge", ltq32, 1'b0);
        check("reg_lt_comb", lt32, 1'b1);
        @(posedge clk);
        #1;
        check("reg_ltq_after_edge", ltq32, 1'b1);
        // asynchronous reset between edges
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_ltq", ltq32, 1'b0);
        check("async_rst_lt", lt32, 1'b1);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_release_ltq_hold", ltq32, 1'b0);
        @(posedge clk);
        #1;
        check("rst_release_ltq_capture", ltq32, 1'b1);
        // new operands are not seen until the next edge
        @(negedge clk);
        a32 = 32'd9; b32 = 32'd3;
        #1;
        check("reg_ltq_hold_old", ltq32, 1'b1);
        @(posedge clk);
        #1;
        check("reg_ltq_capture_0", ltq32, 1'b0);
        @(negedge clk);
`else
        a32 = 32'd3; b32 = 32'd9;
        #1;
        check("comb_ltq_3_9", ltq32, 1'b1);
        a32 = 32'd9; b32 = 32'd3;
        #1;
        check("comb_ltq_9_3", ltq32, 1'b0);
`endif

        // boundaries, N=32
        a32 = 32'h0000_0000; b32 = 32'hFFFF_FFFF; #1;
        check("bnd_0_max_lt", lt32, 1'b1);
        check("bnd_0_max_eq", eq32, 1'b0);
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0000; #1;
        check("bnd_max_0_lt", lt32, 1'b0);
        check("bnd_max_0_eq", eq32, 1'b0);
        a32 = 32'h8000_0000; b32 = 32'h7FFF_FFFF; #1;
        check("bnd_msb_unsigned_lt", lt32, 1'b0);
        a32 = 32'h7FFF_FFFF; b32 = 32'h8000_0000; #1;
        check("bnd_msb_unsigned_lt_rev", lt32, 1'b1);
        a32 = 32'd5; b32 = 32'd5; #1;
        check("bnd_equal_lt", lt32, 1'b0);
        check("bnd_equal_eq", eq32, 1'b1);
        a32 = 32'hFFFF_FFFE; b32 = 32'hFFFF_FFFF; #1;
        check("bnd_adjacent_top_lt", lt32, 1'b1);
        check("bnd_adjacent_top_eq", eq32, 1'b0);
        a32 = 32'h0001_0000; b32 = 32'h0000_FFFF; #1;
        check("bnd_carry_ripple_lt", lt32, 1'b0);

        // N=2 directed
        a2 = 2'd3; b2 = 2'd1; #1;
        check("n2_3_1", lt2, 1'b0);
        a2 = 2'd2; b2 = 2'd1; #1;
        check("n2_2_1", lt2, 1'b0);
        a2 = 2'd1; b2 = 2'd3; #1;
        check("n2_1_3", lt2, 1'b1);

        // N=2 exhaustive
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a2 = 2'(i); b2 = 2'(j);
                #1;
                check($sformatf("n2_ex_lt_%0d_%0d", i, j), lt2, (i < j) ? 1'b1 : 1'b0);
                check($sformatf("n2_ex_eq_%0d_%0d", i, j), eq2, (i == j) ? 1'b1 : 1'b0);
            end
        end

        // N=1: lt = ~a & b
        a1 = 1'b0; b1 = 1'b0; #1; check("n1_0_0", lt1, 1'b0);
        a1 = 1'b0; b1 = 1'b1; #1; check("n1_0_1", lt1, 1'b1);
        a1 = 1'b1; b1 = 1'b0; #1; check("n1_1_0", lt1, 1'b0);
        a1 = 1'b1; b1 = 1'b1; #1; check("n1_1_1", lt1, 1'b0);
        check("n1_1_1_eq", eq1, 1'b1);

        // random N=32, reference is the bench's own relational compare
        for (int k = 0; k < 512; k++) begin
            ra = $urandom;
            rb = (k % 16 == 0) ? ra : ((k % 16 == 1) ? (ra ^ (32'd1 << (k % 32))) : $urandom);
            a32 = ra; b32 = rb;
            #1;
            check($sformatf("rand_lt_%0d_%h_%h", k, ra, rb), lt32, (ra < rb) ? 1'b1 : 1'b0);
            if (k % 16 < 2) begin
                check($sformatf("rand_eq_%0d_%h_%h", k, ra, rb), eq32, (ra == rb) ? 1'b1 : 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sltu
